svi_lane_arbiter: RTL
=====================

// Module: svi_lane_arbiter
// PURPOSE
// - Round-robin scheduler sharing the write side of an SVI array (SIZE lanes) between SIZE requesters.
// - Grants exactly one lane at a time and drives that lane's level-sensitive latch enable.
// - Inserts a dead cycle between grants so no two lane latches are ever transparent together.
// - Sits between requester logic and the lane-writer module; o_en[i] feeds the latch enable of lane i.
// PARAMETERS
// - SIZE      8   number of lanes/requesters (>=2)
// - MAX_HOLD  15  max consecutive HOLD cycles per grant (>=1); used only with SVI_ARB_TIMEOUT_EN
// PORTS
// - i_clk      input   1                single clock, all state on rising edge
// - i_srst     input   1                reset, synchronous, active-high
// - i_req      input   SIZE             per-lane request, level, held until granted/done
// - i_done     input   SIZE             per-lane completion strobe, sampled only for granted lane
// - o_gnt      output  SIZE             one-hot grant, registered
// - o_en       output  SIZE             latch enable = o_gnt & i_req (combinational AND of registered gnt)
// - o_gnt_idx  output  $clog2(SIZE)     index of granted lane, valid while o_busy
// - o_busy     output  1                high in HOLD
// - o_timeout  output  1                1-cycle pulse in GAP after forced release
// BEHAVIOUR
// - Reset (i_srst high at edge): state=IDLE, rr_ptr=0, hold_cnt=0, o_gnt=0, o_gnt_idx=0,
//   o_busy=0, o_timeout=0; o_en=0 as a consequence. Reset wins over every other event, incl. mid-HOLD.
// - FSM states: IDLE, HOLD, GAP.
// - IDLE: if |i_req, winner k = first set bit scanning rr_ptr, rr_ptr+1, ... wrapping mod SIZE;
//   next edge: o_gnt=1<<k, o_gnt_idx=k, o_busy=1, hold_cnt=0, state=HOLD. Else stay IDLE.
// - Latency: request seen at edge N -> o_gnt valid after edge N+1 (one cycle).
// - HOLD: release condition = i_done[k] | ~i_req[k] | timeout (see CONFIGURATION).
//   On release, next edge: o_gnt=0, o_busy=0, rr_ptr=(k+1) mod SIZE, state=GAP.
//   Otherwise hold_cnt increments (saturating at MAX_HOLD).
// - i_done on non-granted lanes is ignored; i_req changes on other lanes do not affect the current grant.
// - GAP: exactly one cycle with all o_gnt/o_en low; then IDLE unconditionally.
//   Minimum spacing between grants is therefore 2 cycles of zero enable after release (GAP + IDLE decision).
// - Simultaneous i_done[k] and timeout: treated as normal release; o_timeout stays 0.
// - Wrap-around: k=SIZE-1 releases -> rr_ptr=0.
// - A lane re-requesting immediately after release is granted again only if no other lane requests.
// - o_gnt is always one-hot or zero; o_gnt_idx holds its last value while not busy.
// CONFIGURATION
// - Macro SVI_ARB_TIMEOUT_EN defined: hold_cnt width $clog2(MAX_HOLD+1).
//   In HOLD, when hold_cnt==MAX_HOLD-1 and there is no other release, a forced release occurs, so a grant
//   is held at most MAX_HOLD cycles. o_timeout=1 during the following GAP cycle.
// - Macro not defined: no counter is built; a grant is held until i_done[k] or ~i_req[k];
//   o_timeout is tied 0. MAX_HOLD is unused.
// TESTING
// - Reset: assert i_srst 2 cycles with i_req=8'hFF -> o_gnt=0, o_busy=0, o_timeout=0 throughout.
// - Single requester: i_req=8'h04 at edge N; i_done[2] at edge N+3 -> o_gnt=8'h04 from N+1 to N+3;
//   GAP at N+4; rr_ptr=3.
// - Round robin: i_req=8'hFF held, i_done pulsed each grant -> grant order 0,1,...,7,0;
//   o_en never has two bits set; >=1 zero cycle between grants.
// - Request drop: lane 5 granted, i_req[5] falls -> o_gnt=0 next edge, o_timeout=0.
// - Timeout (SVI_ARB_TIMEOUT_EN, MAX_HOLD=15): lane 3 held with no i_done -> o_gnt[3] high exactly
//   15 cycles; o_timeout=1 for 1 cycle; the next requester is granted. Without the macro, the grant is held.
// - Reset mid-HOLD: lane 6 granted, i_srst pulsed -> o_gnt=0 next edge; first grant afterwards
//   starts scan at lane 0.

Source files
------------

// File: rtl/svi_lane_arbiter.sv
// rtl/svi_lane_arbiter.sv - round-robin single-lane write arbiter for an SVI latch array
//
// Purpose:
//   Grants the write side of a SIZE-lane SVI array to one requester at a time,
//   drives that lane's level-sensitive latch enable, and inserts a dead (GAP)
//   cycle after each grant so two lane latches are never transparent together.
//
// Ports:
//   i_clk      : single clock, all state on rising edge
//   i_srst     : synchronous active-high reset
//   i_req      : per-lane request level, held until granted/done
//   i_done     : per-lane completion strobe, only the granted lane is looked at
//   o_gnt      : registered one-hot grant (or zero)
//   o_en       : latch enables, o_gnt & i_req
//   o_gnt_idx  : index of the granted lane, holds last value when not busy
//   o_busy     : high while a grant is held
//   o_timeout  : one-cycle pulse in the GAP that follows a forced release
//
// Build option:
//   SVI_ARB_TIMEOUT_EN - when defined, a grant is force-released after MAX_HOLD
//   cycles. When undefined no hold counter exists and o_timeout is tied low.

module svi_lane_arbiter #(
  parameter int SIZE     = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic                    i_clk,
  input  logic                    i_srst,
  input  logic [SIZE-1:0]         i_req,
  input  logic [SIZE-1:0]         i_done,
  output logic [SIZE-1:0]         o_gnt,
  output logic [SIZE-1:0]         o_en,
  output logic [$clog2(SIZE)-1:0] o_gnt_idx,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int IW = $clog2(SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SIZE-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic            timeout_q, timeout_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   scan_pos;
  logic            normal_release;
  logic            hold_expired;
  logic            forced_release;
  logic [IW-1:0]   next_ptr;

  // Round-robin winner: first requesting lane at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    for (int i = 0; i < SIZE; i++) begin
      scan_pos = IW'((int'(rr_ptr_q) + i) % SIZE);
      if (!win_found && i_req[scan_pos]) begin
        win_found = 1'b1;
        win_idx   = scan_pos;
      end
    end
  end

  assign normal_release = i_done[gnt_idx_q] | ~i_req[gnt_idx_q];
  // A timeout coinciding with done/drop counts as a normal release.
  assign forced_release = hold_expired & ~normal_release;
  assign next_ptr       = (gnt_idx_q == IW'(SIZE - 1)) ? '0 : gnt_idx_q + 1'b1;

`ifdef SVI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  // hold_cnt is 0 in the first granted cycle, so reaching MAX_HOLD-1 means
  // this is the MAX_HOLD-th cycle of the grant.
  assign hold_expired = (state_q == ST_HOLD) && (hold_cnt_q == CW'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == ST_IDLE && win_found) begin
      hold_cnt_d = '0;
    end else if (state_q == ST_HOLD && !normal_release && !hold_expired
                 && hold_cnt_q != CW'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_max_hold;

  assign hold_expired    = 1'b0;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d   = ST_HOLD;
          gnt_d     = SIZE'(1) << win_idx;
          gnt_idx_d = win_idx;
        end
      end
      ST_HOLD: begin
        if (normal_release || hold_expired) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          rr_ptr_d  = next_ptr;
          timeout_d = forced_release;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_en      = gnt_q & i_req;
  assign o_gnt_idx = gnt_idx_q;
  assign o_busy    = (state_q == ST_HOLD);
  assign o_timeout = timeout_q;

endmodule
